// File: rtl/rr_arbiter16_if.sv
// Request/grant bundle between the requesting units and the round-robin arbiter.
interface rr_arbiter16_if;
  logic [15:0] req;
  logic        en;
  logic [15:0] gnt;
  logic [3:0]  gnt_idx;
  logic        gnt_valid;

  // Requester side: drives requests and enable, observes the grant.
  modport master (
    output req,
    output en,
    input  gnt,
    input  gnt_idx,
    input  gnt_valid
  );

  // Arbiter side: samples requests and enable, drives the grant.
  modport slave (
    input  req,
    input  en,
    output gnt,
    output gnt_idx,
    output gnt_valid
  );
endinterface

// File: rtl/rr_arbiter16.sv
// 16-way round-robin arbiter with registered one-hot and encoded grant and an
// optional hold limit (MAX_HOLD = 0 disables the limit).
module rr_arbiter16 #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  rr_arbiter16_if.slave   arb
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [7:0] HOLD_LIM = MAX_HOLD[7:0];

  state_t      state_q;
  logic [3:0]  ptr_q;
  logic [7:0]  hcnt_q;
  logic [15:0] gnt_q;
  logic [3:0]  idx_q;
  logic        valid_q;

  logic [3:0]  pick_idx_d;
  logic        pick_vld_d;
  logic [3:0]  cand;
  logic        hold_hit;

  assign hold_hit = (MAX_HOLD != 0) && (hcnt_q == HOLD_LIM);

  // Find the first active request scanning upward from ptr with 4-bit wrap.
  always_comb begin
    pick_idx_d = '0;
    pick_vld_d = 1'b0;
    cand       = '0;
    for (int unsigned k = 0; k < 16; k++) begin
      cand = ptr_q + k[3:0];
      if (!pick_vld_d && arb.req[cand]) begin
        pick_vld_d = 1'b1;
        pick_idx_d = cand;
      end
    end
  end

  // Grant FSM; the release edge never issues a new grant, so grants are
  // always separated by at least one idle cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      hcnt_q  <= '0;
      gnt_q   <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (arb.en && pick_vld_d) begin
            gnt_q   <= 16'd1 << pick_idx_d;
            idx_q   <= pick_idx_d;
            valid_q <= 1'b1;
            hcnt_q  <= 8'd1;
            state_q <= GRANT;
          end
        end
        GRANT: begin
          if (!arb.req[idx_q] || hold_hit) begin
            gnt_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            ptr_q   <= idx_q + 4'd1;
            state_q <= IDLE;
          end else if (hcnt_q != 8'hFF) begin
            hcnt_q  <= hcnt_q + 8'd1;
          end
        end
      endcase
    end
  end

  assign arb.gnt       = gnt_q;
  assign arb.gnt_idx   = idx_q;
  assign arb.gnt_valid = valid_q;

endmodule

// File: tb/tb_rr_arbiter16.sv
// Bench for rr_arbiter16: two instances (MAX_HOLD=2 and MAX_HOLD=0) share the
// same stimulus; a reference model feeds per-instance scoreboard queues.
module tb_rr_arbiter16;

  typedef struct {
    logic [15:0] gnt;
    logic [3:0]  idx;
    logic        vld;
  } exp_t;

  typedef struct {
    logic [15:0] req;
    logic        en;
    logic [3:0]  idx;
    logic        vld;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] req_drv = '0;
  logic        en_drv = 1'b0;

  int n_chk = 0;
  int n_fail = 0;

  exp_t q0[$];
  exp_t q1[$];

  int m_ptr[2];
  int m_idx[2];
  int m_hcnt[2];
  bit m_busy[2];

  rr_arbiter16_if if_h2 ();
  rr_arbiter16_if if_h0 ();

  assign if_h2.req = req_drv;
  assign if_h2.en  = en_drv;
  assign if_h0.req = req_drv;
  assign if_h0.en  = en_drv;

  rr_arbiter16 #(.MAX_HOLD(2)) u_dut_h2 (.clk(clk), .rst_n(rst_n), .arb(if_h2.slave));
  rr_arbiter16 #(.MAX_HOLD(0)) u_dut_h0 (.clk(clk), .rst_n(rst_n), .arb(if_h0.slave));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t act_of(input int d);
    exp_t a;
    if (d == 0) begin
      a.gnt = if_h2.gnt; a.idx = if_h2.gnt_idx; a.vld = if_h2.gnt_valid;
    end else begin
      a.gnt = if_h0.gnt; a.idx = if_h0.gnt_idx; a.vld = if_h0.gnt_valid;
    end
    return a;
  endfunction

  function automatic exp_t model_out(input int d);
    exp_t e;
    e.vld = m_busy[d];
    e.idx = m_busy[d] ? 4'(m_idx[d]) : 4'd0;
    e.gnt = m_busy[d] ? (16'd1 << m_idx[d]) : 16'd0;
    return e;
  endfunction

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      m_ptr[d] = 0; m_idx[d] = 0; m_hcnt[d] = 0; m_busy[d] = 1'b0;
    end
  endfunction

  // One clock edge of the reference behaviour for instance d.
  function automatic void model_edge(input int d, input logic [15:0] r, input logic e, input int mh);
    if (!m_busy[d]) begin
      if (e && (r != 16'd0)) begin
        for (int k = 0; k < 16; k++) begin
          int j;
          j = (m_ptr[d] + k) % 16;
          if (!m_busy[d] && r[j]) begin
            m_busy[d] = 1'b1;
            m_idx[d]  = j;
            m_hcnt[d] = 1;
          end
        end
      end
    end else begin
      if (!r[m_idx[d]] || (mh != 0 && m_hcnt[d] == mh)) begin
        m_busy[d] = 1'b0;
        m_ptr[d]  = (m_idx[d] + 1) % 16;
        m_idx[d]  = 0;
      end else if (m_hcnt[d] < 255) begin
        m_hcnt[d]++;
      end
    end
  endfunction

  task automatic check_exp(input int d, input string tag, input exp_t e);
    exp_t a;
    a = act_of(d);
    chk($sformatf("%s_d%0d_gnt", tag, d), 32'(a.gnt), 32'(e.gnt));
    chk($sformatf("%s_d%0d_idx", tag, d), 32'(a.idx), 32'(e.idx));
    chk($sformatf("%s_d%0d_vld", tag, d), 32'(a.vld), 32'(e.vld));
  endtask

  // Drive one cycle of inputs, push model expectations, pop and compare after the edge.
  task automatic step(input logic [15:0] r, input logic e);
    exp_t x;
    req_drv = r;
    en_drv  = e;
    model_edge(0, r, e, 2);
    model_edge(1, r, e, 0);
    q0.push_back(model_out(0));
    q1.push_back(model_out(1));
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      n_chk++;
      if ((d == 0 ? q0.size() : q1.size()) == 0) begin
        n_fail++;
        $display("FAIL sb_empty_d%0d: got 0 entries expected 1", d);
      end else begin
        x = (d == 0) ? q0.pop_front() : q1.pop_front();
        check_exp(d, "sb", x);
      end
    end
  endtask

  task automatic check_zero(input string tag);
    exp_t z;
    z.gnt = '0; z.idx = '0; z.vld = 1'b0;
    check_exp(0, tag, z);
    check_exp(1, tag, z);
  endtask

  task automatic sync_reset();
    req_drv = '0;
    en_drv  = 1'b0;
    rst_n   = 1'b0;
    model_reset();
    q0.delete();
    q1.delete();
    #1;
    check_zero("rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Per-cycle invariants on both instances.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int d = 0; d < 2; d++) begin
        exp_t a;
        a = act_of(d);
        chk($sformatf("inv_onehot_d%0d", d), 32'($onehot0(a.gnt)), 32'd1);
        chk($sformatf("inv_vld_d%0d", d), 32'(a.vld), 32'(|a.gnt));
        if (a.vld)
          chk($sformatf("inv_dec_d%0d", d), 32'(a.gnt), 32'(16'd1 << a.idx));
      end
    end
  end

  vec_t vt[14];

  initial begin
    // Directed table for the MAX_HOLD=2 instance, starting from reset (ptr=0).
    vt[0]  = '{16'h0020, 1'b1, 4'd5, 1'b1};
    vt[1]  = '{16'h0000, 1'b1, 4'd0, 1'b0};
    vt[2]  = '{16'h0041, 1'b1, 4'd6, 1'b1};
    vt[3]  = '{16'h0041, 1'b1, 4'd6, 1'b1};
    vt[4]  = '{16'h0041, 1'b1, 4'd0, 1'b0};
    vt[5]  = '{16'h0041, 1'b1, 4'd0, 1'b1};
    vt[6]  = '{16'h0000, 1'b1, 4'd0, 1'b0};
    vt[7]  = '{16'h0008, 1'b1, 4'd3, 1'b1};
    vt[8]  = '{16'h0108, 1'b0, 4'd3, 1'b1};
    vt[9]  = '{16'h0108, 1'b0, 4'd0, 1'b0};
    vt[10] = '{16'h0108, 1'b0, 4'd0, 1'b0};
    vt[11] = '{16'h0108, 1'b1, 4'd8, 1'b1};
    vt[12] = '{16'h0000, 1'b1, 4'd0, 1'b0};
    vt[13] = '{16'h0000, 1'b0, 4'd0, 1'b0};

    model_reset();
    #2;
    sync_reset();

    for (int i = 0; i < 14; i++) begin
      exp_t t;
      step(vt[i].req, vt[i].en);
      t.vld = vt[i].vld;
      t.idx = vt[i].idx;
      t.gnt = vt[i].vld ? (16'd1 << vt[i].idx) : 16'd0;
      check_exp(0, $sformatf("tbl%0d", i), t);
    end

    // Rotation and 15 -> 0 wrap: each requester drops for one cycle after its grant.
    sync_reset();
    for (int k = 0; k < 17; k++) begin
      logic [15:0] drop;
      step(16'hFFFF, 1'b1);
      chk($sformatf("rot%0d_idx_h0", k), 32'(if_h0.gnt_idx), 32'(k % 16));
      chk($sformatf("rot%0d_vld_h0", k), 32'(if_h0.gnt_valid), 32'd1);
      drop = 16'hFFFF & ~(16'd1 << (k % 16));
      step(drop, 1'b1);
      chk($sformatf("rot%0d_idle_h2", k), 32'(if_h2.gnt_valid), 32'd0);
    end

    // Fairness: 0x8001 held, MAX_HOLD=2 alternates 0,0,idle,15,15,idle.
    sync_reset();
    for (int i = 0; i < 12; i++) begin
      int ph;
      step(16'h8001, 1'b1);
      ph = i % 6;
      chk($sformatf("fair%0d_vld", i), 32'(if_h2.gnt_valid), (ph == 2 || ph == 5) ? 32'd0 : 32'd1);
      chk($sformatf("fair%0d_idx", i), 32'(if_h2.gnt_idx), (ph == 3 || ph == 4) ? 32'd15 : 32'd0);
    end

    // Enable gating on the unlimited instance: idx 3 kept until req[3] drops.
    sync_reset();
    step(16'h0008, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(16'h0108, 1'b0);
      chk($sformatf("en_hold%0d", i), 32'(if_h0.gnt_idx), 32'd3);
    end
    step(16'h0100, 1'b0);
    chk("en_release", 32'(if_h0.gnt_valid), 32'd0);
    step(16'h0100, 1'b0);
    chk("en_nogrant", 32'(if_h0.gnt_valid), 32'd0);
    step(16'h0100, 1'b1);
    chk("en_grant8", 32'(if_h0.gnt_idx), 32'd8);

    // Saturation: long hold on the unlimited instance never drops.
    for (int i = 0; i < 300; i++) step(16'h0100, 1'b1);
    chk("sat_hold", 32'(if_h0.gnt_idx), 32'd8);

    // Asynchronous reset mid-grant, then pointer restarts at 0.
    sync_reset();
    step(16'h0200, 1'b1);
    chk("ar_pre_idx", 32'(if_h0.gnt_idx), 32'd9);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("ar_mid");
    model_reset();
    q0.delete();
    q1.delete();
    #2;
    rst_n = 1'b1;
    step(16'h0201, 1'b1);
    chk("ar_post_idx", 32'(if_h2.gnt_idx), 32'd0);

    step(16'h0000, 1'b1);
    step(16'h0000, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_arbiter16.md
# rr_arbiter16

Round-robin arbiter that shares a single resource among 16 requesters. It grants one requester at a time, reporting the grant both one-hot and as a 4-bit encoded index that matches the 16-to-4 encoder output format. An optional hold limit bounds how long any single requester keeps the resource. It sits between the requesting units and the shared datapath; the encoded index drives the datapath's select lines.

## Interface
- MAX_HOLD, default 8: maximum consecutive cycles one grant may be held; 0 = unlimited. Legal range 0..255.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  16  request lines; req[i] high = requester i wants the resource.
- en  input  1  arbitration enable; gates new grants only.
- gnt  output  16  one-hot grant, registered; all zero when no grant.
- gnt_idx  output  4  binary index of granted requester, registered; 0 when no grant.
- gnt_valid  output  1  high while a grant is active; equals |gnt.

## Operation
- FSM has two states, IDLE and GRANT. The internal state is a 4-bit round-robin pointer ptr and an 8-bit hold counter hcnt.
- Reset (rst_n low, asynchronous):
  - state=IDLE, ptr=0, hcnt=0.
  - gnt=16'h0000, gnt_idx=0, gnt_valid=0.
- IDLE, when en=1 and |req=1:
  - Select the first i with req[i]=1, scanning ptr, ptr+1, ..., 15, 0, ..., ptr-1 (mod 16).
  - Register gnt=1<<i, gnt_idx=i, gnt_valid=1, hcnt=1. Go to GRANT.
- IDLE, when en=0 or req=0: hold all outputs at 0. ptr is unchanged.
- GRANT, each edge:
  - If req[gnt_idx]=0: normal release. gnt=0, gnt_idx=0, gnt_valid=0, ptr=gnt_idx+1 (4-bit wrap, 15 -> 0). Go to IDLE.
  - Else if MAX_HOLD!=0 and hcnt==MAX_HOLD: forced release, same updates as a normal release. The requester must re-arbitrate and now has the lowest priority.
  - Else: keep the grant and increment hcnt. hcnt saturates at 255 when MAX_HOLD=0.
- en=0 during GRANT does not preempt the current grant. Release and timeout still apply.
- Changes to other req bits during GRANT are ignored until the next arbitration.
- Requests are not latched. A req pulse that is low at the IDLE sampling edge is lost.

## Timing
- Grant latency is 1 cycle. A req sampled high at edge t in IDLE gives gnt valid after edge t.
- Release latency is 1 cycle. If req[gnt_idx] is sampled low at edge t, gnt clears after edge t.
- There is at least one idle cycle between consecutive grants, because the release edge never issues a new grant. Minimum grant period is 2 cycles.
- With MAX_HOLD=M>0 and the request held continuously, gnt stays high for exactly M cycles, followed by 1 idle cycle.
- All outputs are registered. There is no combinational path from req or en to any output.
- Asserting rst_n low mid-grant clears outputs immediately, without waiting for clk. ptr returns to 0.

## Test plan
- Reset and single request: assert rst_n=0, then release it; en=1, req=16'h0020 held. Required: after the first edge gnt=16'h0020, gnt_idx=5, gnt_valid=1. Drop req; after the next edge gnt=0 and ptr=6.
- Rotation and wrap: req=16'hFFFF held high, each requester dropping its req for one cycle after it is granted, MAX_HOLD=0. Required: grants go to indices 0, 1, 2, ..., 15, 0, each separated by one idle cycle. Checks the 15 -> 0 wrap.
- Fairness with two requesters: req=16'h8001 held continuously, MAX_HOLD=2. Required: idx 0 for 2 cycles, idle, idx 15 for 2 cycles, idle, idx 0, and so on. Neither requester is starved.
- Enable gating: grant idx 3 active, then en=0 with req=16'h0108. Required: idx 3 keeps its grant until req[3] drops. No new grant while en=0. After en=1, idx 8 is granted after one edge.
- Asynchronous reset mid-grant: grant idx 9 active, pulse rst_n low between clock edges. Required: gnt=0, gnt_idx=0, gnt_valid=0 before the next edge. After reset, with req=16'h0201, idx 0 is granted because ptr was reset to 0.
- Invariants checked every cycle: gnt is one-hot or zero; gnt_valid==|gnt; gnt==1<<gnt_idx whenever gnt_valid=1.
